rsa_arbiter: RTL and testbench

RSA_ARBITER -- requirements
Module: rsa_arbiter

---
 rtl/rsa_arbiter.sv | 160 ++++++++++++++++
 tb/tb_rsa_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_arbiter.sv
// Two-requester round-robin arbiter in front of a shared RSA unit (IDLE/RUN/DONE).
// Define RSA_ARB_TIMEOUT_EN to abort a RUN lasting TIMEOUT_CYCLES cycles with an error response.
module rsa_arbiter #(
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_p,
  input  logic [WIDTH-1:0] req0_e,
  input  logic [WIDTH-1:0] req0_m,
  input  logic [WIDTH-1:0] req0_const,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_p,
  input  logic [WIDTH-1:0] req1_e,
  input  logic [WIDTH-1:0] req1_m,
  input  logic [WIDTH-1:0] req1_const,
  output logic             resp0_valid,
  output logic [WIDTH-1:0] resp0_result,
  output logic             resp0_err,
  output logic             resp1_valid,
  output logic [WIDTH-1:0] resp1_result,
  output logic             resp1_err,
  output logic             rsa_en,
  output logic [WIDTH-1:0] rsa_p,
  output logic [WIDTH-1:0] rsa_e,
  output logic [WIDTH-1:0] rsa_m,
  output logic [WIDTH-1:0] rsa_const,
  input  logic             rsa_eoc,
  input  logic [WIDTH-1:0] rsa_c,
  output logic             busy,
  output logic             owner
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic             ptr;
  logic             grant0;
  logic             grant1;
  logic             finish;
  logic [WIDTH-1:0] fin_result;

`ifdef RSA_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic          fin_err;
`endif

  // A lone valid requester always wins; on contention the pointer decides.
  assign grant0 = rst_n && (state == IDLE) && req0_valid && (!req1_valid || !ptr);
  assign grant1 = rst_n && (state == IDLE) && req1_valid && (!req0_valid || ptr);
  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign busy       = (state != IDLE);

  always_comb begin
    finish     = 1'b0;
    fin_result = rsa_c;
`ifdef RSA_ARB_TIMEOUT_EN
    fin_err    = 1'b0;
`endif
    if (state == RUN) begin
      if (rsa_eoc) begin
        finish = 1'b1;
      end
`ifdef RSA_ARB_TIMEOUT_EN
      else if (cnt == CW'(TIMEOUT_CYCLES)) begin
        finish     = 1'b1;
        fin_result = '0;
        fin_err    = 1'b1;
      end
`endif
    end
  end

`ifndef RSA_ARB_TIMEOUT_EN
  assign resp0_err = 1'b0;
  assign resp1_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= 1'b0;
      owner        <= 1'b0;
      rsa_en       <= 1'b0;
      rsa_p        <= '0;
      rsa_e        <= '0;
      rsa_m        <= '0;
      rsa_const    <= '0;
      resp0_valid  <= 1'b0;
      resp1_valid  <= 1'b0;
      resp0_result <= '0;
      resp1_result <= '0;
`ifdef RSA_ARB_TIMEOUT_EN
      resp0_err    <= 1'b0;
      resp1_err    <= 1'b0;
      cnt          <= '0;
`endif
    end else begin
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
`ifdef RSA_ARB_TIMEOUT_EN
      resp0_err   <= 1'b0;
      resp1_err   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            owner     <= grant1;
            rsa_p     <= grant1 ? req1_p     : req0_p;
            rsa_e     <= grant1 ? req1_e     : req0_e;
            rsa_m     <= grant1 ? req1_m     : req0_m;
            rsa_const <= grant1 ? req1_const : req0_const;
            rsa_en    <= 1'b1;
            state     <= RUN;
`ifdef RSA_ARB_TIMEOUT_EN
            cnt       <= '0;
`endif
          end
        end
        RUN: begin
          // Response pulse is registered here so it is visible for the whole DONE cycle.
          if (finish) begin
            rsa_en <= 1'b0;
            state  <= DONE;
            if (owner) begin
              resp1_valid  <= 1'b1;
              resp1_result <= fin_result;
`ifdef RSA_ARB_TIMEOUT_EN
              resp1_err    <= fin_err;
`endif
            end else begin
              resp0_valid  <= 1'b1;
              resp0_result <= fin_result;
`ifdef RSA_ARB_TIMEOUT_EN
              resp0_err    <= fin_err;
`endif
            end
          end
`ifdef RSA_ARB_TIMEOUT_EN
          else begin
            cnt <= cnt + CW'(1);
          end
`endif
        end
        DONE: begin
          ptr   <= ~owner;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_arbiter.sv
// Directed self-checking bench for rsa_arbiter with a small latency-programmable RSA model.
module tb_rsa_arbiter;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_p = '0, req0_e = '0, req0_m = '0, req0_const = '0;
  logic [WIDTH-1:0] req1_p = '0, req1_e = '0, req1_m = '0, req1_const = '0;
  logic             resp0_valid, resp1_valid, resp0_err, resp1_err;
  logic [WIDTH-1:0] resp0_result, resp1_result;
  logic             rsa_en, rsa_eoc, busy, owner;
  logic [WIDTH-1:0] rsa_p, rsa_e, rsa_m, rsa_const, rsa_c;

  int checks = 0;
  int failures = 0;

  int               modelLat = 0;
  logic             echoMode = 1'b0;
  logic [WIDTH-1:0] modelC = '0;
  logic             spurEoc = 1'b0;
  int               runCnt = 0;

  int               cyc = 0, hsCycLast = 0, resp0Cyc = 0;
  int               resp0Count = 0, resp1Count = 0, respTotal = 0;
  int               enRun = 0, lastEnLen = 0;
  logic [WIDTH-1:0] lastResult0 = '0, lastResult1 = '0;
  logic             lastErr0 = 1'b0;
  int               grantLog[$];
  int               base;

  always #5 clk = ~clk;

  rsa_arbiter #(.WIDTH(WIDTH), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_p(req0_p), .req0_e(req0_e), .req0_m(req0_m), .req0_const(req0_const),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_p(req1_p), .req1_e(req1_e), .req1_m(req1_m), .req1_const(req1_const),
    .resp0_valid(resp0_valid), .resp0_result(resp0_result), .resp0_err(resp0_err),
    .resp1_valid(resp1_valid), .resp1_result(resp1_result), .resp1_err(resp1_err),
    .rsa_en(rsa_en), .rsa_p(rsa_p), .rsa_e(rsa_e), .rsa_m(rsa_m), .rsa_const(rsa_const),
    .rsa_eoc(rsa_eoc), .rsa_c(rsa_c), .busy(busy), .owner(owner)
  );

  // RSA model: eoc during the modelLat-th enabled cycle; modelLat=0 never finishes.
  always @(posedge clk) runCnt <= rsa_en ? runCnt + 1 : 0;
  assign rsa_eoc = (rsa_en && modelLat != 0 && runCnt == modelLat - 1) || spurEoc;
  assign rsa_c   = echoMode ? ~rsa_p : modelC;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [WIDTH-1:0] p0,
                               input logic v1, input logic [WIDTH-1:0] p1);
    req0_valid = v0; req0_p = p0;
    req1_valid = v1; req1_p = p1;
  endtask

  task automatic waitForResp(input int target, input string tag);
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk); #3;
      if (respTotal >= target) break;
    end
    checkOutput({tag, "_resp_timeout"}, (respTotal >= target), 1);
  endtask

  // Passive monitor sampling 2 time units after the falling edge.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (req0_ready && req1_ready) checkOutput("one_ready", 1, 0);
      if (req0_valid && req0_ready) begin grantLog.push_back(0); hsCycLast = cyc; end
      if (req1_valid && req1_ready) begin grantLog.push_back(1); hsCycLast = cyc; end
      if (resp0_valid) begin
        resp0Count++; respTotal++; lastResult0 = resp0_result; lastErr0 = resp0_err; resp0Cyc = cyc;
      end
      if (resp1_valid) begin
        resp1Count++; respTotal++; lastResult1 = resp1_result;
      end
    end
    if (rsa_en) enRun++;
    else begin
      if (enRun > 0) lastEnLen = enRun;
      enRun = 0;
    end
    cyc++;
  end

  initial begin
    // Reset state, with a request pending to prove ready is held off.
    repeat (2) @(negedge clk);
    req0_valid = 1'b1;
    #3;
    checkOutput("rst_ready0", req0_ready, 0);
    checkOutput("rst_ready1", req1_ready, 0);
    checkOutput("rst_rsa_en", rsa_en, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_owner", owner, 0);
    checkOutput("rst_resp0_valid", resp0_valid, 0);
    checkOutput("rst_rsa_p", rsa_p, 0);
    @(negedge clk); req0_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk);

    // Single job from requester 0, latency 20.
    modelLat = 20; modelC = 8'h2A;
    req0_e = 8'd17; req0_m = 8'd65; req0_const = 8'h55;
    applyStimulus(1'b1, 8'd61, 1'b0, 8'd0);
    #3;
    checkOutput("single_ready0", req0_ready, 1);
    checkOutput("single_ready1", req1_ready, 0);
    @(negedge clk); applyStimulus(1'b0, 8'd99, 1'b0, 8'd0);
    waitForResp(1, "single");
    checkOutput("single_resp0_count", resp0Count, 1);
    checkOutput("single_resp1_count", resp1Count, 0);
    checkOutput("single_result", lastResult0, 8'h2A);
    checkOutput("single_err", lastErr0, 0);
    checkOutput("single_en_len", lastEnLen, 20);
    checkOutput("single_latency", resp0Cyc - hsCycLast, 21);
    checkOutput("single_rsa_p_held", rsa_p, 61);
    checkOutput("single_rsa_e_held", rsa_e, 17);
    checkOutput("single_owner", owner, 0);
    repeat (2) @(negedge clk); #3;
    checkOutput("single_idle_busy", busy, 0);

    // Spurious eoc while idle.
    @(negedge clk); spurEoc = 1'b1;
    @(negedge clk); spurEoc = 1'b0;
    repeat (2) @(negedge clk); #3;
    checkOutput("spur_busy", busy, 0);
    checkOutput("spur_rsa_en", rsa_en, 0);
    checkOutput("spur_resp_total", respTotal, 1);

    // Simultaneous requests from reset, then fairness over 6 jobs.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    grantLog.delete();
    echoMode = 1'b1; modelLat = 3; base = respTotal;
    applyStimulus(1'b1, 8'd11, 1'b1, 8'd22);
    #3;
    checkOutput("simul_ready0", req0_ready, 1);
    checkOutput("simul_ready1", req1_ready, 0);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (grantLog.size() >= 6) break;
    end
    applyStimulus(1'b0, 8'd11, 1'b0, 8'd22);
    checkOutput("fair_grant_count", grantLog.size(), 6);
    waitForResp(base + 6, "fair");
    for (int i = 0; i < 6 && i < grantLog.size(); i++)
      checkOutput($sformatf("fair_grant%0d", i), grantLog[i], i % 2);
    checkOutput("fair_en_len", lastEnLen, 3);
    checkOutput("fair_result0", lastResult0, 8'hF4);
    checkOutput("fair_result1", lastResult1, 8'hE9);
    checkOutput("fair_owner", owner, 1);

    // One job for requester 0 so the pointer now favours requester 1.
    modelLat = 2; base = respTotal;
    @(negedge clk); applyStimulus(1'b1, 8'd33, 1'b0, 8'd0);
    @(negedge clk); applyStimulus(1'b0, 8'd33, 1'b0, 8'd0);
    waitForResp(base + 1, "prep");

    // Reset in the middle of a RUN for requester 1.
    modelLat = 0;
    @(negedge clk); applyStimulus(1'b0, 8'd0, 1'b1, 8'd44);
    #3;
    checkOutput("midrst_ready1", req1_ready, 1);
    @(negedge clk); applyStimulus(1'b0, 8'd0, 1'b0, 8'd44);
    repeat (4) @(negedge clk);
    #3;
    checkOutput("midrst_pre_busy", busy, 1);
    rst_n = 1'b0; base = respTotal;
    #1;
    checkOutput("midrst_rsa_en", rsa_en, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_owner", owner, 0);
    checkOutput("midrst_rsa_p", rsa_p, 0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    checkOutput("midrst_no_resp", respTotal, base);
    modelLat = 2;
    @(negedge clk); applyStimulus(1'b1, 8'd55, 1'b1, 8'd66);
    #3;
    checkOutput("midrst_next_ready0", req0_ready, 1);
    checkOutput("midrst_next_ready1", req1_ready, 0);
    @(negedge clk); applyStimulus(1'b0, 8'd55, 1'b0, 8'd66);
    waitForResp(base + 1, "midrst_next");
    checkOutput("midrst_next_result", lastResult0, 8'hC8);

    // Model that never finishes.
    modelLat = 0; echoMode = 1'b0; base = respTotal;
    @(negedge clk); applyStimulus(1'b1, 8'd77, 1'b0, 8'd0);
    @(negedge clk); applyStimulus(1'b0, 8'd77, 1'b0, 8'd0);
`ifdef RSA_ARB_TIMEOUT_EN
    waitForResp(base + 1, "timeout");
    checkOutput("timeout_latency", resp0Cyc - hsCycLast, 10);
    checkOutput("timeout_err", lastErr0, 1);
    checkOutput("timeout_result", lastResult0, 0);
    @(negedge clk); #3;
    checkOutput("timeout_err_clear", resp0_err, 0);
`else
    repeat (30) @(negedge clk);
    #3;
    checkOutput("noto_busy", busy, 1);
    checkOutput("noto_no_resp", respTotal, base);
    checkOutput("noto_err", resp0_err, 0);
`endif
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
